// File: rtl/aes_pkg.sv
// Shared AES datapath types and pipeline-depth limits.
// Used by pipeline_stage and pipeline_reg.
package aes_pkg;

    // One AES state block is 128 bits wide.
    localparam int AES_STATE_W = 128;

    typedef logic [AES_STATE_W-1:0] aes_state_t;

    // The register slice supports between 1 and 16 cascaded stages.
    localparam int PIPE_DEPTH_MIN = 1;
    localparam int PIPE_DEPTH_MAX = 16;

    // Width of a counter that can hold any legal depth value, 0..PIPE_DEPTH_MAX.
    localparam int PIPE_DEPTH_CNT_W = $clog2(PIPE_DEPTH_MAX + 1);

    // True when the requested stage count is supported.
    function automatic bit pipe_depth_ok(input int depth);
        return (depth >= PIPE_DEPTH_MIN) && (depth <= PIPE_DEPTH_MAX);
    endfunction

    // True when the requested data width is usable.
    function automatic bit pipe_width_ok(input int width);
        return width >= 1;
    endfunction

endpackage : aes_pkg

// File: rtl/pipeline_stage.sv
// One register stage of the AES datapath pipeline: a single flop bank with
// an asynchronous, active-low reset to a configurable value. No enable, so
// every rising clock edge captures the input word.
module pipeline_stage
    import aes_pkg::*;
#(
    parameter int               WIDTH       = AES_STATE_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state value: the incoming word, bit for bit.
    always_comb begin
        data_d = d;
    end

    // Capture the word on every rising edge; clear to RESET_VALUE at once when reset_n falls.
    // NOTE: the flop bank uses non-blocking assignments, so all stages sample their
    // inputs before any of them updates and a word moves exactly one stage per edge.
    // NOTE: every stage is reset (not only the last one) so words in flight are discarded
    // and q cannot show stale data from before reset once the pipe refills.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    // The output is the flop itself, with no logic in between.
    assign q = data_q;

endmodule : pipeline_stage

// File: rtl/pipeline_reg.sv
// Register slice placed between AES round stages to break long combinational
// paths. DEPTH cascaded pipeline_stage instances delay d by DEPTH clock edges;
// there is no handshake, so the pipe advances on every rising edge.
//
// Optional build macro PIPELINE_REG_ASSERT_EN compiles in SVA checks for the
// reset value, X-freedom and the DEPTH-cycle latency. The datapath is the same
// with or without the macro.
module pipeline_reg
    import aes_pkg::*;
#(
    parameter int               WIDTH       = AES_STATE_W,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!pipe_depth_ok(DEPTH)) begin : g_bad_depth
        $error("pipeline_reg: DEPTH=%0d is outside the legal range %0d..%0d",
               DEPTH, PIPE_DEPTH_MIN, PIPE_DEPTH_MAX);
    end

    if (!pipe_width_ok(WIDTH)) begin : g_bad_width
        $error("pipeline_reg: WIDTH=%0d must be at least 1", WIDTH);
    end

    // ------------------------------------------------------------------
    // Stage chain: stage_in[0] is the module input, and each later stage
    // takes the output of the stage before it.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] stage_in  [DEPTH];
    logic [WIDTH-1:0] stage_out [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign stage_in[i] = d;
        end else begin : g_next
            assign stage_in[i] = stage_out[i-1];
        end

        pipeline_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (stage_in[i]),
            .q       (stage_out[i])
        );
    end

    // The last stage drives q directly.
    assign q = stage_out[DEPTH-1];

`ifdef PIPELINE_REG_ASSERT_EN
    // ------------------------------------------------------------------
    // Checker state. It observes the pipe and does not drive it.
    // ------------------------------------------------------------------
    logic [PIPE_DEPTH_CNT_W-1:0] live_edges_d;
    logic [PIPE_DEPTH_CNT_W-1:0] live_edges_q;
    logic [DEPTH-1:0]            x_hist_d;
    logic [DEPTH-1:0]            x_hist_q;

    // Count the edges since reset release, saturating at DEPTH. Shift in one
    // X flag per edge so the last DEPTH samples of d are remembered.
    always_comb begin
        live_edges_d = live_edges_q;
        if (live_edges_q != PIPE_DEPTH_CNT_W'(DEPTH)) begin
            live_edges_d = live_edges_q + 1'b1;
        end
        x_hist_d = (x_hist_q << 1) | DEPTH'($isunknown(d));
    end

    // Checker flops. They share the datapath reset, so the history starts
    // clean when reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_edges_q <= '0;
            x_hist_q     <= '0;
        end else begin
            live_edges_q <= live_edges_d;
            x_hist_q     <= x_hist_d;
        end
    end

    // While reset is held, q must sit at RESET_VALUE.
    a_reset_value : assert property (
        @(posedge clk) !reset_n |-> (q == RESET_VALUE)
    ) else $error("pipeline_reg: q != RESET_VALUE during reset");

    // Out of reset, q carries no X unless an X entered on d within the last DEPTH edges.
    a_no_x : assert property (
        @(posedge clk) disable iff (!reset_n)
        (x_hist_q == '0) |-> !$isunknown(q)
    ) else $error("pipeline_reg: X on q without an X on d");

    // Once the pipe has refilled after reset, q is d delayed by DEPTH edges.
    a_latency : assert property (
        @(posedge clk) disable iff (!reset_n)
        (live_edges_q == PIPE_DEPTH_CNT_W'(DEPTH)) |-> (q === $past(d, DEPTH))
    ) else $error("pipeline_reg: q does not equal d delayed by DEPTH edges");
`endif

endmodule : pipeline_reg

// File: tb/tb_pipeline_reg.sv
// Directed, table-driven bench for pipeline_reg. Three instances share one
// clock, reset and input: the default DEPTH=1 slice, a DEPTH=3 slice, and a
// DEPTH=2 slice with RESET_VALUE=128'hA5.
module tb_pipeline_reg;

    localparam logic [127:0] V_A   = 128'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] V_B   = 128'hFFFF_FFFF_FFFF_FF11;
    localparam logic [127:0] V_C   = {128{1'b1}};
    localparam logic [127:0] V_D   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] V_E   = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
    localparam logic [127:0] RV_A5 = 128'hA5;

    typedef struct {
        logic [127:0] d;
        logic [127:0] q1;   // expected on the DEPTH=1 instance
        logic [127:0] q3;   // expected on the DEPTH=3 instance
        logic [127:0] qrv;  // expected on the DEPTH=2, RESET_VALUE=A5 instance
    } vec_t;

    logic         clk;
    logic         reset_n;
    logic [127:0] d;
    logic [127:0] q1;
    logic [127:0] q3;
    logic [127:0] qrv;

    int n_vec;
    int n_err;

    vec_t vecs [10];

    pipeline_reg u_dut_d1 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d),
        .q       (q1)
    );

    pipeline_reg #(
        .DEPTH (3)
    ) u_dut_d3 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d),
        .q       (q3)
    );

    pipeline_reg #(
        .DEPTH       (2),
        .RESET_VALUE (RV_A5)
    ) u_dut_rv (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d),
        .q       (qrv)
    );

    // 10-unit clock period, with rising edges at t = 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [127:0] e1,
                             input logic [127:0] e3, input logic [127:0] erv);
        check({tag, " q1"},  q1,  e1);
        check({tag, " q3"},  q3,  e3);
        check({tag, " qrv"}, qrv, erv);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Expected outputs after each edge, worked out by hand. The DEPTH=3 pipe
        // starts full of zeros and the DEPTH=2 pipe starts full of A5.
        vecs[0] = '{d: V_A,    q1: V_A,    q3: '0,     qrv: RV_A5};
        vecs[1] = '{d: V_B,    q1: V_B,    q3: '0,     qrv: V_A};
        vecs[2] = '{d: V_C,    q1: V_C,    q3: V_A,    qrv: V_B};
        vecs[3] = '{d: V_D,    q1: V_D,    q3: V_B,    qrv: V_C};
        vecs[4] = '{d: 128'd1, q1: 128'd1, q3: V_C,    qrv: V_D};
        vecs[5] = '{d: 128'd2, q1: 128'd2, q3: V_D,    qrv: 128'd1};
        vecs[6] = '{d: 128'd3, q1: 128'd3, q3: 128'd1, qrv: 128'd2};
        vecs[7] = '{d: 128'd4, q1: 128'd4, q3: 128'd2, qrv: 128'd3};
        vecs[8] = '{d: '0,     q1: '0,     q3: 128'd3, qrv: 128'd4};
        vecs[9] = '{d: '0,     q1: '0,     q3: 128'd4, qrv: '0};

        // Reset asserted mid-cycle at t=6 clears every instance immediately.
        reset_n = 1'b1;
        d       = V_A;
        #6;
        reset_n = 1'b0;
        #1;  // t=7, before the next rising edge
        check_all("async reset", '0, '0, RV_A5);
        #4;  // t=11
        check_all("reset t11", '0, '0, RV_A5);

        // Release at t=11. Nothing is captured until the next rising edge.
        reset_n = 1'b1;
        #1;  // t=12
        check_all("release no capture", '0, '0, RV_A5);

        // Main table. Each new d is driven 1 unit after an edge. q1 is checked
        // mid-cycle to confirm it still holds the previous word, then all three
        // outputs are checked after the following edge.
        for (int i = 0; i < 10; i++) begin
            d = vecs[i].d;
            if (i > 0) begin
                #3;
                check($sformatf("vec%0d hold q1", i), q1, vecs[i-1].q1);
            end
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].q1, vecs[i].q3, vecs[i].qrv);
        end

        // Words are in flight in the DEPTH=3 pipe (q3=4). A reset between edges
        // clears every instance without waiting for a clock edge.
        d = V_D;
        #2;
        reset_n = 1'b0;
        #1;
        check_all("mid-op reset", '0, '0, RV_A5);

        // Hold reset across several edges while d toggles. Outputs must stay at reset values.
        for (int k = 0; k < 4; k++) begin
            d = k[0] ? V_C : V_D;
            @(posedge clk);
            #1;
            check_all($sformatf("held reset e%0d", k), '0, '0, RV_A5);
        end

        // Release away from an edge. The words that were in flight must not
        // come back; only the new word V_E travels through.
        reset_n = 1'b1;
        d       = V_E;
        @(posedge clk);
        #1;
        check_all("refill e1", V_E, '0, RV_A5);
        @(posedge clk);
        #1;
        check_all("refill e2", V_E, '0, V_E);
        @(posedge clk);
        #1;
        check_all("refill e3", V_E, V_E, V_E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipeline_reg
